// File: rtl/recv_inference_result.sv
// Receives TCP segments (metadata + payload) and writes each into a host ring buffer via DMA
// command/data streams; drops empty or oversized segments and keeps run statistics.
module recv_inference_result #(
    parameter int unsigned BEAT_BYTES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_axis_rx_metadata_valid,
    output logic                s_axis_rx_metadata_ready,
    input  logic [47:0]         s_axis_rx_metadata_data,
    input  logic                s_axis_rx_data_valid,
    output logic                s_axis_rx_data_ready,
    input  logic [511:0]        s_axis_rx_data_data,
    input  logic [63:0]         s_axis_rx_data_keep,
    input  logic                s_axis_rx_data_last,
    output logic                axis_dma_write_cmd_valid,
    input  logic                axis_dma_write_cmd_ready,
    output logic [63:0]         axis_dma_write_cmd_address,
    output logic [31:0]         axis_dma_write_cmd_length,
    output logic                axis_dma_write_data_valid,
    input  logic                axis_dma_write_data_ready,
    output logic [511:0]        axis_dma_write_data_data,
    output logic [63:0]         axis_dma_write_data_keep,
    output logic                axis_dma_write_data_last,
    input  logic [14:0][31:0]   control_reg,
    output logic [7:0][31:0]    status_reg
);

    localparam int unsigned Lsb = $clog2(BEAT_BYTES);

    typedef enum logic [2:0] {StIdle, StCmd, StData, StDrop, StUpdate} state_e;

    function automatic logic [32:0] beats_of(input logic [31:0] len);
        beats_of = ({1'b0, len} + 33'(BEAT_BYTES - 1)) >> Lsb;
    endfunction

    function automatic logic [32:0] round_up(input logic [31:0] len);
        round_up = beats_of(len) << Lsb;
    endfunction

    state_e             state_q, state_d;
    logic [14:0][31:0]  ctrl_q;
    logic [31:0]        len_q, wr_ptr_q;
    logic [32:0]        beats_q, beat_cnt_q;
    logic [31:0]        lat_q, seg_q, bytes_q, drop_q;
    logic               armed_q;

    logic        start_edge, meta_hs, rx_hs, last_beat, drop_seg, wrap_at_accept;
    logic [31:0] meta_len, ring_size;
    logic [32:0] upd_sum;
    logic        ctrl_unused;

    assign ring_size      = ctrl_q[2];
    assign meta_len       = s_axis_rx_metadata_data[47:16];
    assign start_edge     = control_reg[3][0] & ~ctrl_q[3][0];
    assign meta_hs        = s_axis_rx_metadata_valid & s_axis_rx_metadata_ready;
    assign rx_hs          = s_axis_rx_data_valid & s_axis_rx_data_ready;
    assign last_beat      = (beat_cnt_q == beats_q - 33'd1);
    assign drop_seg       = (meta_len == 32'd0) || (meta_len > ring_size);
    // A segment that would cross the ring end restarts at offset 0 instead.
    assign wrap_at_accept = ({1'b0, wr_ptr_q} + round_up(meta_len)) > {1'b0, ring_size};
    assign upd_sum        = {1'b0, wr_ptr_q} + round_up(len_q);
    assign ctrl_unused    = ^{ctrl_q[14:4], ctrl_q[3][31:1], s_axis_rx_data_last,
                              s_axis_rx_metadata_data[15:0]};

    always_comb begin
        state_d                   = state_q;
        s_axis_rx_metadata_ready  = 1'b0;
        s_axis_rx_data_ready      = 1'b0;
        axis_dma_write_cmd_valid  = 1'b0;
        axis_dma_write_data_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_axis_rx_metadata_ready = 1'b1;
                if (s_axis_rx_metadata_valid) state_d = drop_seg ? StDrop : StCmd;
            end
            StCmd: begin
                axis_dma_write_cmd_valid = 1'b1;
                if (axis_dma_write_cmd_ready) state_d = StData;
            end
            StData: begin
                s_axis_rx_data_ready      = axis_dma_write_data_ready;
                axis_dma_write_data_valid = s_axis_rx_data_valid;
                if (rx_hs && last_beat) state_d = StUpdate;
            end
            StDrop: begin
                s_axis_rx_data_ready = 1'b1;
                if (s_axis_rx_data_valid && last_beat) state_d = StIdle;
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (rst) begin
            s_axis_rx_metadata_ready  = 1'b0;
            s_axis_rx_data_ready      = 1'b0;
            axis_dma_write_cmd_valid  = 1'b0;
            axis_dma_write_data_valid = 1'b0;
        end
    end

    assign axis_dma_write_cmd_address = {ctrl_q[1], ctrl_q[0]} + {32'd0, wr_ptr_q};
    assign axis_dma_write_cmd_length  = len_q;
    assign axis_dma_write_data_data   = s_axis_rx_data_data;
    assign axis_dma_write_data_keep   = s_axis_rx_data_keep;
    assign axis_dma_write_data_last   = (state_q == StData) && last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            len_q      <= '0;
            beats_q    <= 33'd1;
            beat_cnt_q <= '0;
            wr_ptr_q   <= '0;
            seg_q      <= '0;
            bytes_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= control_reg;
            if (meta_hs) begin
                len_q      <= meta_len;
                beats_q    <= (meta_len == 32'd0) ? 33'd1 : beats_of(meta_len);
                beat_cnt_q <= '0;
            end else if (rx_hs) begin
                beat_cnt_q <= beat_cnt_q + 33'd1;
            end
            // A new start clears statistics but lets the segment in flight complete.
            if (start_edge) begin
                wr_ptr_q <= '0;
                seg_q    <= '0;
                bytes_q  <= '0;
                drop_q   <= '0;
            end else begin
                if (meta_hs && !drop_seg && wrap_at_accept) wr_ptr_q <= '0;
                if (state_q == StUpdate) begin
                    wr_ptr_q <= (upd_sum == {1'b0, ring_size}) ? 32'd0 : upd_sum[31:0];
                    seg_q    <= seg_q + 32'd1;
                    bytes_q  <= bytes_q + len_q;
                end
                if (state_q == StDrop && rx_hs && last_beat) drop_q <= drop_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q   <= '0;
            armed_q <= 1'b0;
        end else if (start_edge) begin
            lat_q   <= '0;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            lat_q <= lat_q + 32'd1;
            if (rx_hs) armed_q <= 1'b0;
        end
    end

    always_comb begin
        status_reg    = '0;
        status_reg[0] = lat_q;
        status_reg[1] = seg_q;
        status_reg[2] = bytes_q;
        status_reg[3] = drop_q;
        status_reg[4] = wr_ptr_q;
        status_reg[5] = {29'd0, state_q};
    end

endmodule

// File: tb/tb_recv_inference_result.sv
// Directed bench for recv_inference_result: ring placement, wrap, drop, backpressure, latency.
module tb_recv_inference_result;

    logic               clk = 1'b0;
    logic               rst;
    logic               meta_valid, meta_ready;
    logic [47:0]        meta_data;
    logic               rx_valid, rx_ready, rx_last;
    logic [511:0]       rx_data;
    logic [63:0]        rx_keep;
    logic               cmd_valid, cmd_ready;
    logic [63:0]        cmd_addr;
    logic [31:0]        cmd_len;
    logic               wd_valid, wd_ready, wd_last;
    logic [511:0]       wd_data;
    logic [63:0]        wd_keep;
    logic [14:0][31:0]  ctrl;
    logic [7:0][31:0]   status;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    recv_inference_result #(.BEAT_BYTES(64)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .s_axis_rx_metadata_valid   (meta_valid),
        .s_axis_rx_metadata_ready   (meta_ready),
        .s_axis_rx_metadata_data    (meta_data),
        .s_axis_rx_data_valid       (rx_valid),
        .s_axis_rx_data_ready       (rx_ready),
        .s_axis_rx_data_data        (rx_data),
        .s_axis_rx_data_keep        (rx_keep),
        .s_axis_rx_data_last        (rx_last),
        .axis_dma_write_cmd_valid   (cmd_valid),
        .axis_dma_write_cmd_ready   (cmd_ready),
        .axis_dma_write_cmd_address (cmd_addr),
        .axis_dma_write_cmd_length  (cmd_len),
        .axis_dma_write_data_valid  (wd_valid),
        .axis_dma_write_data_ready  (wd_ready),
        .axis_dma_write_data_data   (wd_data),
        .axis_dma_write_data_keep   (wd_keep),
        .axis_dma_write_data_last   (wd_last),
        .control_reg                (ctrl),
        .status_reg                 (status)
    );

    function automatic logic [511:0] pat(input logic [7:0] tag, input int idx);
        logic [15:0] i16;
        i16 = 16'(idx);
        pat = {16{tag, 8'h5A, i16}};
    endfunction

    function automatic logic [63:0] kp(input int idx);
        logic [63:0] ones;
        ones = '1;
        kp = ones >> (idx % 5);
    endfunction

    // Sends one segment and follows it to completion, checking command and every output beat.
    task automatic run_segment(input logic [31:0] len, input int nbeats, input bit exp_cmd,
                               input logic [63:0] exp_addr, input bit bp, input logic [7:0] tag);
        int idx = 0, oidx = 0, cmds = 0, cyc = 0, exp_out;
        bit ok = 0, done = 0;
        logic [63:0] caddr = '0;
        logic [31:0] clen = '0;
        exp_out = exp_cmd ? nbeats : 0;
        @(negedge clk);
        meta_valid = 1'b1;
        meta_data  = {len, 8'h00, tag};
        for (int i = 0; i < 20; i++) begin
            if (meta_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 meta_valid = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL seg%0h meta_accept timeout", tag); return; end
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (idx == nbeats && meta_ready) begin done = 1; break; end
            cmd_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            wd_ready  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            rx_valid  = (idx < nbeats) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            rx_data   = pat(tag, idx);
            rx_keep   = kp(idx);
            rx_last   = (idx == 0);
            #1;
            cyc++;
            if (cmd_valid && cmd_ready) begin cmds++; caddr = cmd_addr; clen = cmd_len; end
            if (wd_valid && wd_ready) begin
                n_checks++;
                if (wd_data !== pat(tag, oidx)) begin
                    n_fail++; $display("FAIL seg%0h beat%0d data got %h exp %h", tag, oidx,
                                       wd_data, pat(tag, oidx));
                end
                n_checks++;
                if (wd_keep !== kp(oidx)) begin
                    n_fail++; $display("FAIL seg%0h beat%0d keep got %h exp %h", tag, oidx,
                                       wd_keep, kp(oidx));
                end
                n_checks++;
                if (wd_last !== (oidx == exp_out - 1)) begin
                    n_fail++; $display("FAIL seg%0h beat%0d last got %b exp %b", tag, oidx,
                                       wd_last, (oidx == exp_out - 1));
                end
                oidx++;
            end
            if (rx_valid && rx_ready) idx++;
        end
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL seg%0h completion timeout consumed %0d of %0d",
                                            tag, idx, nbeats); end
        n_checks++;
        if (cmds != (exp_cmd ? 1 : 0)) begin
            n_fail++; $display("FAIL seg%0h cmd_count got %0d exp %0d", tag, cmds, exp_cmd ? 1 : 0);
        end
        if (exp_cmd) begin
            n_checks++;
            if (caddr !== exp_addr) begin
                n_fail++; $display("FAIL seg%0h cmd_addr got %h exp %h", tag, caddr, exp_addr);
            end
            n_checks++;
            if (clen !== len) begin
                n_fail++; $display("FAIL seg%0h cmd_len got %0d exp %0d", tag, clen, len);
            end
        end
        n_checks++;
        if (oidx != exp_out) begin
            n_fail++; $display("FAIL seg%0h out_beats got %0d exp %0d", tag, oidx, exp_out);
        end
        if (!bp) begin
            n_checks++;
            if (cyc != (exp_cmd ? nbeats + 2 : nbeats)) begin
                n_fail++; $display("FAIL seg%0h cycles got %0d exp %0d", tag, cyc,
                                   exp_cmd ? nbeats + 2 : nbeats);
            end
        end
    endtask

    task automatic check_status(input string name, input int f, input logic [31:0] exp);
        n_checks++;
        if (status[f] !== exp) begin
            n_fail++; $display("FAIL %s status[%0d] got %h exp %h", name, f, status[f], exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({meta_ready, cmd_valid, wd_valid, rx_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs got %b exp 0000",
                               {meta_ready, cmd_valid, wd_valid, rx_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (meta_ready !== 1'b1) begin n_fail++; $display("FAIL idle_meta_ready got %b exp 1",
                                                          meta_ready); end
        n_checks++;
        if (status !== '0) begin n_fail++; $display("FAIL reset_status got %h exp 0", status); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        ctrl[0] = 32'h1000_0000;
        ctrl[1] = 32'h0;
        ctrl[2] = 32'h1000;
        ctrl[3] = 32'h1;
        repeat (2) @(negedge clk);
        run_segment(32'd256, 4, 1'b1, 64'h1000_0000, 1'b0, 8'h01);
        check_status("basic", 4, 32'h100);
        check_status("basic", 1, 32'd1);
        check_status("basic", 2, 32'd256);
    endtask

    task automatic test_partial();
        run_segment(32'd100, 2, 1'b1, 64'h1000_0100, 1'b0, 8'h02);
        check_status("partial", 4, 32'h180);
        run_segment(32'hD80, 54, 1'b1, 64'h1000_0180, 1'b0, 8'h03);
        check_status("fill", 4, 32'hF00);
        check_status("fill", 2, 32'd3812);
    endtask

    task automatic test_wrap();
        run_segment(32'd512, 8, 1'b1, 64'h1000_0000, 1'b0, 8'h04);
        check_status("wrap", 4, 32'h200);
        check_status("wrap", 1, 32'd4);
    endtask

    task automatic test_drop();
        run_segment(32'd0, 1, 1'b0, 64'h0, 1'b0, 8'h05);
        run_segment(32'h2000, 128, 1'b0, 64'h0, 1'b0, 8'h06);
        check_status("drop", 3, 32'd2);
        check_status("drop", 4, 32'h200);
        check_status("drop", 1, 32'd4);
    endtask

    task automatic test_backpressure();
        run_segment(32'd1000, 16, 1'b1, 64'h1000_0200, 1'b1, 8'h07);
        check_status("bp", 4, 32'h600);
        check_status("bp", 2, 32'd5324);
    endtask

    task automatic test_ring_end();
        run_segment(32'hA00, 40, 1'b1, 64'h1000_0600, 1'b0, 8'h08);
        check_status("ring_end", 4, 32'h0);
        check_status("ring_end", 1, 32'd6);
        check_status("ring_end", 2, 32'd7884);
        check_status("ring_end", 5, 32'd0);
        check_status("ring_end", 6, 32'd0);
        check_status("ring_end", 7, 32'd0);
    endtask

    task automatic test_latency();
        @(negedge clk);
        ctrl[3] = 32'h0;
        @(negedge clk);
        ctrl[3] = 32'h1;
        @(posedge clk);
        #1;
        check_status("lat_start", 0, 32'd0);
        check_status("lat_start", 1, 32'd0);
        check_status("lat_start", 2, 32'd0);
        repeat (48) @(posedge clk);
        #1;
        meta_valid = 1'b1;
        meta_data  = {32'd0, 16'h0009};
        rx_valid   = 1'b1;
        rx_data    = pat(8'h09, 0);
        rx_keep    = '1;
        rx_last    = 1'b1;
        @(posedge clk);
        #1 meta_valid = 1'b0;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        check_status("latency", 0, 32'd50);
        repeat (10) @(posedge clk);
        #1;
        check_status("lat_hold", 0, 32'd50);
        check_status("lat_hold", 3, 32'd1);
        @(negedge clk);
        ctrl[3] = 32'h0;
        @(negedge clk);
        ctrl[3] = 32'h1;
        @(posedge clk);
        #1;
        check_status("lat_restart", 0, 32'd0);
        check_status("lat_restart", 3, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        meta_valid = 1'b0;
        meta_data  = '0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        rx_keep    = '0;
        rx_last    = 1'b0;
        cmd_ready  = 1'b0;
        wd_ready   = 1'b0;
        ctrl       = '0;
        test_reset();
        test_basic();
        test_partial();
        test_wrap();
        test_drop();
        test_backpressure();
        test_ring_end();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/recv_inference_result.md
RECV_INFERENCE_RESULT -- requirements
Module: recv_inference_result

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 64: bytes per data beat; the only supported value is 64.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port s_axis_rx_metadata, axis_meta.slave, 48 data: [15:0] session, [47:16] segment length in bytes.
REQ-005 SHALL have port s_axis_rx_data, axi_stream.slave, 512 data / 64 keep / last: TCP receive payload.
REQ-006 SHALL have port axis_dma_write_cmd, axis_mem_cmd.master, 64 address / 32 length: host write command.
REQ-007 SHALL have port axis_dma_write_data, axi_stream.master, 512/64/last: host write data.
REQ-008 SHALL have port control_reg, input, [14:0][31:0]: [1:0] ring base address (hi:lo), [2] ring size in bytes (multiple of 64), [3][0] start.
REQ-009 SHALL have port status_reg, output, [7:0][31:0]: [0] latency, [1] segments written, [2] bytes written, [3] segments dropped, [4] write pointer, [5] FSM state.

Function
REQ-010 SHALL register control_reg each cycle; start_edge = start & ~start_q.
REQ-011 start_edge SHALL clear wr_ptr, all counters and latency, and arm the latency timer.
REQ-012 FSM states SHALL be IDLE, CMD, DATA, DROP, UPDATE.
REQ-013 IDLE: meta ready=1; on meta handshake latch len; next = DROP if len==0 or len>ring_size, else CMD.
REQ-014 On meta acceptance, if wr_ptr+round64(len) > ring_size, wr_ptr SHALL wrap to 0 before CMD; a segment never straddles the ring end.
REQ-015 CMD: cmd valid=1, address=base+wr_ptr, length=len; stay until ready; then DATA.
REQ-016 DATA: beats = ceil(len/64); rx_data.ready = dma_write_data.ready; data/keep pass through unchanged.
REQ-017 Write-data last SHALL be generated from the beat counter on beat number beats; the incoming last is ignored.
REQ-018 On last beat handshake: go to UPDATE.
REQ-019 DROP: rx_data.ready=1; consume ceil(len/64) beats, or 1 beat if len==0; increment dropped; then IDLE; no DMA traffic.
REQ-020 UPDATE: wr_ptr += round64(len); if result == ring_size, wr_ptr=0; segments+=1; bytes+=len; then IDLE (1 cycle).
REQ-021 Meta ready SHALL be 0 outside IDLE; rx_data.ready SHALL be 0 in IDLE, CMD, UPDATE.
REQ-022 Latency counter SHALL run from the cycle after start_edge until the first rx_data handshake; then hold.
REQ-023 Counters SHALL be 32-bit and wrap modulo 2^32 with no saturation.
REQ-024 start_edge mid-segment SHALL clear counters only; the FSM SHALL finish the current segment.
REQ-025 Throughput in DATA SHALL be 1 beat per cycle with no bubbles when both sides are ready.

Reset
REQ-026 On rst: FSM=IDLE; wr_ptr, counters and latency=0; timer disarmed; cmd valid=0; write-data valid=0; meta ready=0 during the reset cycle.
REQ-027 rst SHALL abort any segment in flight without emitting last; the upstream is reset together with this block.
REQ-028 status_reg[7:6] SHALL read 0.

Verification
REQ-029 base=0x1000_0000, ring=0x1000, start; meta len=256 -> cmd addr 0x1000_0000 len 256; 4 beats, last on beat 4; wr_ptr=0x100; seg=1, bytes=256.
REQ-030 len=100 -> 2 beats, last on beat 2, keep unchanged; wr_ptr advances by 128.
REQ-031 wr_ptr=0xF00, len=512 -> wrap; cmd addr=base; wr_ptr=0x200 afterwards.
REQ-032 len=0 and len=0x2000 (>ring) -> dropped=2, no cmd, 1 and 128 beats drained respectively.
REQ-033 Random ready backpressure on cmd and data -> data order and beat count preserved, no beats lost or duplicated.
REQ-034 Start, first rx beat 50 cycles later -> latency=50, then held; a second start clears it to 0.
